// File: rtl/vx_warp_stall_arb_if.sv
// Scheduler-side channel bundle for vx_warp_stall_arb.
// master = arbiter, slave = warp control / decode / fetch side.
interface vx_warp_stall_arb_if #(
  parameter int NUM_WARPS = 4,
  parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
  logic [NUM_WARPS-1:0] active_mask;
  logic                 decode_valid;
  logic                 decode_is_wstall;
  logic [NW_WIDTH-1:0]  decode_wid;
  logic                 unlock_valid;
  logic [NW_WIDTH-1:0]  unlock_wid;
  logic                 sched_valid;
  logic [NW_WIDTH-1:0]  sched_wid;
  logic                 sched_ready;
  logic [NUM_WARPS-1:0] stalled_mask;

  modport master (
    input  active_mask,
    input  decode_valid,
    input  decode_is_wstall,
    input  decode_wid,
    input  unlock_valid,
    input  unlock_wid,
    input  sched_ready,
    output sched_valid,
    output sched_wid,
    output stalled_mask
  );

  modport slave (
    output active_mask,
    output decode_valid,
    output decode_is_wstall,
    output decode_wid,
    output unlock_valid,
    output unlock_wid,
    output sched_ready,
    input  sched_valid,
    input  sched_wid,
    input  stalled_mask
  );
endinterface

// File: rtl/vx_warp_stall_arb.sv
// Round-robin warp scheduler with per-warp IDLE/PENDING/WSTALL tracking.
// Optional WSTALL_PERF_EN adds a saturating 44-bit wstall cycle counter.
module vx_warp_stall_arb #(
  parameter int NUM_WARPS = 4,
  parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_warp_stall_arb_if.master  bus
`ifdef WSTALL_PERF_EN
  ,
  output logic [43:0]          perf_wstall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    WSTALL  = 2'd2
  } wst_e;

  wst_e                 st_q [NUM_WARPS];
  wst_e                 st_d [NUM_WARPS];
  logic [NW_WIDTH-1:0]  rr_q;
  logic [NW_WIDTH-1:0]  rr_d;
  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] stalled;
  logic [NUM_WARPS-1:0] fire_hit;
  logic [NUM_WARPS-1:0] dec_hit;
  logic [NUM_WARPS-1:0] unl_hit;
  logic                 found;
  logic [NW_WIDTH-1:0]  pick;
  logic [NW_WIDTH-1:0]  idx;
  logic                 fire;

  always_comb begin
    elig    = '0;
    stalled = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w]    = bus.active_mask[w] && (st_q[w] == IDLE);
      stalled[w] = (st_q[w] != IDLE);
    end
  end

  // Offer depends only on registered state and active_mask.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_q + NW_WIDTH'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign bus.sched_valid  = found;
  assign bus.sched_wid    = pick;
  assign bus.stalled_mask = stalled;
  assign fire             = found && bus.sched_ready;

  always_comb begin
    fire_hit = '0;
    dec_hit  = '0;
    unl_hit  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      fire_hit[w] = fire && (pick == NW_WIDTH'(w));
      dec_hit[w]  = bus.decode_valid
                 && (bus.decode_wid == NW_WIDTH'(w));
      unl_hit[w]  = bus.unlock_valid
                 && (bus.unlock_wid == NW_WIDTH'(w));
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (fire)
      rr_d = pick + NW_WIDTH'(1);
    for (int w = 0; w < NUM_WARPS; w++) begin
      st_d[w] = st_q[w];
      unique case (1'b1)
        (st_q[w] == IDLE): begin
          if (fire_hit[w])
            st_d[w] = PENDING;
        end
        (st_q[w] == PENDING): begin
          // A same-cycle unlock cancels the stall.
          if (dec_hit[w])
            st_d[w] = (bus.decode_is_wstall && !unl_hit[w])
                    ? WSTALL : IDLE;
        end
        (st_q[w] == WSTALL): begin
          if (unl_hit[w])
            st_d[w] = IDLE;
        end
        default: st_d[w] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
      for (int w = 0; w < NUM_WARPS; w++)
        st_q[w] <= IDLE;
    end else begin
      rr_q <= rr_d;
      for (int w = 0; w < NUM_WARPS; w++)
        st_q[w] <= st_d[w];
    end
  end

`ifdef WSTALL_PERF_EN
  logic any_ws;

  always_comb begin
    any_ws = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++)
      if (st_q[w] == WSTALL)
        any_ws = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      perf_wstall_cycles <= '0;
    else if (any_ws && !(&perf_wstall_cycles))
      perf_wstall_cycles <= perf_wstall_cycles + 44'd1;
  end
`endif

endmodule

// File: tb/tb_vx_warp_stall_arb.sv
// Directed-vector bench for vx_warp_stall_arb, NUM_WARPS=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_vx_warp_stall_arb;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  vx_warp_stall_arb_if #(.NUM_WARPS(4), .NW_WIDTH(2)) bus ();

`ifdef WSTALL_PERF_EN
  logic [43:0] perf;
`endif

  vx_warp_stall_arb #(
    .NUM_WARPS(4),
    .NW_WIDTH (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef WSTALL_PERF_EN
    ,
    .perf_wstall_cycles(perf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dec(input logic [1:0] wid, input logic ws);
    bus.decode_valid     = 1'b1;
    bus.decode_wid       = wid;
    bus.decode_is_wstall = ws;
    tick();
    bus.decode_valid     = 1'b0;
    bus.decode_is_wstall = 1'b0;
  endtask

  task automatic unl(input logic [1:0] wid);
    bus.unlock_valid = 1'b1;
    bus.unlock_wid   = wid;
    tick();
    bus.unlock_valid = 1'b0;
  endtask

  task automatic fire1();
    bus.sched_ready = 1'b1;
    tick();
    bus.sched_ready = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    bus.active_mask      = 4'b0000;
    bus.decode_valid     = 1'b0;
    bus.decode_is_wstall = 1'b0;
    bus.decode_wid       = 2'd0;
    bus.unlock_valid     = 1'b0;
    bus.unlock_wid       = 2'd0;
    bus.sched_ready      = 1'b0;
    tick();
    chk("rst_stalled", 64'(bus.stalled_mask), 64'h0);
    chk("rst_valid_noact", 64'(bus.sched_valid), 64'h0);
    bus.active_mask = 4'b1111;
    #1;
    chk("rst_valid_act", 64'(bus.sched_valid), 64'h1);
`ifdef WSTALL_PERF_EN
    chk("rst_perf", 64'(perf), 64'h0);
`endif

    // Back-to-back fires 0,1,2,3.
    reset           = 1'b0;
    bus.sched_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_v%0d", i), 64'(bus.sched_valid), 64'h1);
      chk($sformatf("rr_wid%0d", i), 64'(bus.sched_wid), 64'(i));
      tick();
    end
    bus.sched_ready = 1'b0;
    chk("all_pend_valid", 64'(bus.sched_valid), 64'h0);
    chk("all_pend_mask", 64'(bus.stalled_mask), 64'hf);

    // Warp 2 wstalls; held off until unlock.
    dec(2'd2, 1'b1);
    chk("ws2_mask", 64'(bus.stalled_mask), 64'hf);
    chk("ws2_valid", 64'(bus.sched_valid), 64'h0);
    dec(2'd0, 1'b0);
    chk("rel0_mask", 64'(bus.stalled_mask), 64'he);
    chk("rel0_wid", 64'(bus.sched_wid), 64'h0);
    fire1();
    chk("ws2_still_valid", 64'(bus.sched_valid), 64'h0);
    chk("ws2_still_mask", 64'(bus.stalled_mask), 64'hf);
    unl(2'd2);
    chk("unl2_valid", 64'(bus.sched_valid), 64'h1);
    chk("unl2_wid", 64'(bus.sched_wid), 64'h2);
    chk("unl2_mask", 64'(bus.stalled_mask), 64'hb);

    // Warp 1: wstall decode and unlock in the same cycle.
    bus.unlock_valid = 1'b1;
    bus.unlock_wid   = 2'd1;
    dec(2'd1, 1'b1);
    bus.unlock_valid = 1'b0;
    chk("race1_mask", 64'(bus.stalled_mask), 64'h9);
    chk("race1_wid", 64'(bus.sched_wid), 64'h1);

    // Fire warp 1 while releasing warp 3.
    bus.sched_ready = 1'b1;
    dec(2'd3, 1'b0);
    bus.sched_ready = 1'b0;
    chk("fire_rel_mask", 64'(bus.stalled_mask), 64'h3);
    chk("fire_rel_wid", 64'(bus.sched_wid), 64'h2);

    // Stray unlock and decode for idle warp 3.
    bus.unlock_valid = 1'b1;
    bus.unlock_wid   = 2'd3;
    dec(2'd3, 1'b1);
    bus.unlock_valid = 1'b0;
    chk("stray_mask", 64'(bus.stalled_mask), 64'h3);
    chk("stray_wid", 64'(bus.sched_wid), 64'h2);

    // rr_ptr=3 with eligible {0,3}, ready held low.
    fire1();
    chk("rr3_wid", 64'(bus.sched_wid), 64'h3);
    dec(2'd0, 1'b0);
    chk("elig03_mask", 64'(bus.stalled_mask), 64'h6);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_wid%0d", i), 64'(bus.sched_wid), 64'h3);
      tick();
    end
    fire1();
    chk("after3_valid", 64'(bus.sched_valid), 64'h1);
    chk("after3_wid", 64'(bus.sched_wid), 64'h0);

    // Dropping active bit makes warp 0 ineligible, state kept.
    bus.active_mask = 4'b1110;
    #1;
    chk("inact_valid", 64'(bus.sched_valid), 64'h0);
    chk("inact_mask", 64'(bus.stalled_mask), 64'he);
    bus.active_mask = 4'b1111;
    #1;
    chk("react_wid", 64'(bus.sched_wid), 64'h0);

    // Warps 0,1 wstalled, then reset with stray decode/unlock.
    fire1();
    dec(2'd0, 1'b1);
    dec(2'd1, 1'b1);
    chk("ws01_mask", 64'(bus.stalled_mask), 64'hf);
`ifdef WSTALL_PERF_EN
    chk("perf_count", 64'(perf), 64'h1);
`endif
    reset            = 1'b1;
    bus.unlock_valid = 1'b1;
    bus.unlock_wid   = 2'd0;
    dec(2'd2, 1'b1);
    bus.unlock_valid = 1'b0;
    reset            = 1'b0;
    chk("mid_rst_mask", 64'(bus.stalled_mask), 64'h0);
    chk("mid_rst_wid", 64'(bus.sched_wid), 64'h0);
`ifdef WSTALL_PERF_EN
    chk("mid_rst_perf", 64'(perf), 64'h0);
`endif
    tick();
    chk("post_rst_mask", 64'(bus.stalled_mask), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vx_warp_stall_arb.md
VX_WARP_STALL_ARB -- requirements
Module: VX_warp_stall_arb

Interface
REQ-001 SHALL have parameter NUM_WARPS, default `NUM_WARPS, warp count (power of two, 2..32).
REQ-002 SHALL have parameter NW_WIDTH, default `LOG2UP(NUM_WARPS), warp id width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port active_mask  in  NUM_WARPS  warps currently enabled by warp control.
REQ-006 SHALL have port decode_valid  in  1  decode report valid (decode-to-scheduler channel).
REQ-007 SHALL have port decode_is_wstall  in  1  reported instruction stalls its warp.
REQ-008 SHALL have port decode_wid  in  NW_WIDTH  warp of the decode report.
REQ-009 SHALL have port unlock_valid  in  1  stall resolution (branch/warp-control commit) valid.
REQ-010 SHALL have port unlock_wid  in  NW_WIDTH  warp to unlock.
REQ-011 SHALL have port sched_valid  out  1  a warp is offered to fetch.
REQ-012 SHALL have port sched_wid  out  NW_WIDTH  offered warp id.
REQ-013 SHALL have port sched_ready  in  1  fetch accepts; fire = sched_valid & sched_ready.
REQ-014 SHALL have port stalled_mask  out  NUM_WARPS  warps currently pending or wstalled (debug).

Function
REQ-015 SHALL keep per-warp state, encoded IDLE, PENDING or WSTALL.
REQ-016 A warp SHALL be eligible when active_mask[w]=1 and state IDLE.
REQ-017 sched_valid SHALL be high combinationally whenever any warp is eligible; sched_wid SHALL be the first eligible warp at or above rr_ptr, wrapping modulo NUM_WARPS.
REQ-018 sched_valid/sched_wid SHALL depend only on registered state and active_mask, never on sched_ready.
REQ-019 On fire, the selected warp SHALL move IDLE->PENDING next cycle and rr_ptr SHALL become sched_wid+1 modulo NUM_WARPS.
REQ-020 On decode_valid with warp in PENDING: decode_is_wstall=0 -> IDLE; decode_is_wstall=1 -> WSTALL.
REQ-021 On unlock_valid with warp in WSTALL, the warp SHALL move to IDLE.
REQ-022 Decode reports for warps not PENDING and unlocks for warps not WSTALL SHALL be ignored.
REQ-023 Same-cycle decode_is_wstall=1 and unlock for the same warp PENDING: result SHALL be IDLE (unlock wins).
REQ-024 Same-cycle fire and decode release targeting the same warp is impossible (warp not IDLE); fire of warp A and release of warp B SHALL both apply.
REQ-025 A warp whose active_mask bit drops SHALL keep its state; it is merely ineligible.
REQ-026 stalled_mask[w] SHALL be 1 exactly when state[w] is not IDLE (registered).
REQ-027 Each warp SHALL have at most one instruction between fire and decode report.

Reset
REQ-028 While reset=1 at a clock edge: all warps IDLE, rr_ptr=0, stalled_mask=0; sched_valid then depends only on active_mask.
REQ-029 Reset mid-operation SHALL discard all PENDING/WSTALL state; decode/unlock inputs in the reset cycle SHALL be ignored.

Configuration
REQ-030 With WSTALL_PERF_EN defined, SHALL add output perf_wstall_cycles (44 bits): increments by 1 each cycle any warp is in WSTALL, saturating, reset to 0.
REQ-031 Without WSTALL_PERF_EN, the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 NUM_WARPS=4, active_mask=4'b1111, sched_ready=1 after reset -> fires wid 0,1,2,3 on consecutive cycles, then sched_valid=0, stalled_mask=4'b1111.
REQ-033 Warp 2 PENDING, decode_valid=1 is_wstall=1 wid=2 -> stalled_mask[2] stays 1, warp 2 never offered until unlock_valid wid=2, then offered next cycle.
REQ-034 Warp 1 PENDING, same-cycle decode wstall and unlock for wid 1 -> warp 1 IDLE next cycle, stalled_mask[1]=0.
REQ-035 rr_ptr=3, eligible {0,3}, sched_ready=0 for 5 cycles -> sched_wid holds 3 stable; on ready fires 3, then offers 0.
REQ-036 Warps 0,1 WSTALL, reset pulsed one cycle -> stalled_mask=0, next offer is wid 0; with WSTALL_PERF_EN perf_wstall_cycles=0.
REQ-037 unlock_valid wid=3 while warp 3 IDLE, and decode_valid wid=3 while IDLE -> no state change, no spurious offer ordering change.
